// File: rtl/input_cond_pkg.sv
// Shared constants and button state encoding for the input conditioner.
// Counter width covers the largest default timing parameter (6,000,000 < 2**23).
package input_cond_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 60000;
    localparam int DEF_REPEAT_DELAY    = 6000000;
    localparam int DEF_REPEAT_PERIOD   = 1200000;
    localparam int CNT_W               = 23;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_e;

endpackage

// File: rtl/input_conditioner_debounce.sv
// One-bit two-flop synchronizer followed by a stability counter.
// The debounced state only changes after the synchronized input disagrees with it for DEBOUNCE_CYCLES cycles.
module debounce
    import input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CW              = CNT_W
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic deb_o
);

    localparam logic [CW-1:0] DEB_TC = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter stops at terminal count, so it can never wrap.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == DEB_TC) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces a push-button and a slide switch; produces button increment pulses with
// optional auto-repeat, plus a registered switch level and edge strobes.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic sw_raw,
    input  logic repeat_en,
    output logic btn_pulse,
    output logic sw_level,
    output logic sw_rise,
    output logic sw_fall
);

    localparam logic [CNT_W-1:0] DLY_TC = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_TC = CNT_W'(REPEAT_PERIOD - 1);

    logic             btn_deb;
    logic             sw_deb;
    logic             btn_prev_q;
    btn_state_e       state_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic             btn_pulse_q;
    logic             sw_level_q;
    logic             sw_rise_q;
    logic             sw_fall_q;

    debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CW              (CNT_W)
    ) u_btn_deb (
        .clk_i (clk),
        .rst_i (rst),
        .raw_i (btn_raw),
        .deb_o (btn_deb)
    );

    debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CW              (CNT_W)
    ) u_sw_deb (
        .clk_i (clk),
        .rst_i (rst),
        .raw_i (sw_raw),
        .deb_o (sw_deb)
    );

    // sw_level_q doubles as the previous debounced value for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_level_q <= 1'b0;
            sw_rise_q  <= 1'b0;
            sw_fall_q  <= 1'b0;
        end else begin
            sw_level_q <= sw_deb;
            sw_rise_q  <= sw_deb & ~sw_level_q;
            sw_fall_q  <= ~sw_deb & sw_level_q;
        end
    end

    // A low debounced button overrides any terminal count; a pulse is never
    // issued directly after another, which keeps REPEAT_PERIOD == 1 legal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev_q  <= 1'b0;
            state_q     <= ST_IDLE;
            hold_cnt_q  <= '0;
            btn_pulse_q <= 1'b0;
        end else begin
            btn_prev_q  <= btn_deb;
            btn_pulse_q <= 1'b0;
            if (!btn_deb) begin
                state_q    <= ST_IDLE;
                hold_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (!btn_prev_q) begin
                            btn_pulse_q <= 1'b1;
                            hold_cnt_q  <= '0;
                            state_q     <= ST_HELD;
                        end
                    end
                    ST_HELD: begin
                        if (hold_cnt_q == DLY_TC) begin
                            if (repeat_en && !btn_pulse_q) begin
                                btn_pulse_q <= 1'b1;
                                hold_cnt_q  <= '0;
                                state_q     <= ST_REPEAT;
                            end
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!repeat_en) begin
                            state_q    <= ST_HELD;
                            hold_cnt_q <= DLY_TC;
                        end else if (hold_cnt_q == PER_TC) begin
                            if (!btn_pulse_q) begin
                                btn_pulse_q <= 1'b1;
                                hold_cnt_q  <= '0;
                            end
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q    <= ST_IDLE;
                        hold_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign btn_pulse = btn_pulse_q;
    assign sw_level  = sw_level_q;
    assign sw_rise   = sw_rise_q;
    assign sw_fall   = sw_fall_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with short timing parameters.
module tb_input_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic sw_raw;
    logic repeat_en;
    logic btn_pulse;
    logic sw_level;
    logic sw_rise;
    logic sw_fall;

    always #5 clk = ~clk;

    input_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .sw_raw    (sw_raw),
        .repeat_en (repeat_en),
        .btn_pulse (btn_pulse),
        .sw_level  (sw_level),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_pulse, cnt_rise, cnt_fall, dbl_pulse;
    logic prev_pulse;

    typedef struct {
        logic btn;
        logic sw;
        logic rep;
        int   n;
        int   exp_pulse;
        int   exp_rise;
        int   exp_fall;
        logic exp_level;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_tally();
        cnt_pulse = 0;
        cnt_rise  = 0;
        cnt_fall  = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cnt_pulse += int'(btn_pulse);
        cnt_rise  += int'(sw_rise);
        cnt_fall  += int'(sw_fall);
        if (btn_pulse && prev_pulse) dbl_pulse++;
        prev_pulse = btn_pulse;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        btn_raw   = 1'b0;
        sw_raw    = 1'b0;
        repeat_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        prev_pulse = 1'b0;
        clr_tally();
    endtask

    initial begin
        int first, np, rise_at, lvl_at, p1, p2;
        int rel_q[$];
        int exp_rel [7];

        dbl_pulse  = 0;
        prev_pulse = 1'b0;
        clr_tally();
        btn_raw   = 1'b0;
        sw_raw    = 1'b0;
        repeat_en = 1'b0;
        rst       = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("reset_btn_pulse", int'(btn_pulse), 0);
        check("reset_sw_level",  int'(sw_level),  0);
        check("reset_sw_rise",   int'(sw_rise),   0);
        check("reset_sw_fall",   int'(sw_fall),   0);
        do_reset();

        //            btn   sw    rep   n   pls rise fall level
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 10, 0, 0, 0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 10, 1, 0, 0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 30, 0, 0, 0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 10, 0, 0, 0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 10, 0, 1, 0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0,  5, 0, 0, 0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 10, 0, 0, 1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0,  2, 0, 0, 0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0,  6, 0, 0, 0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 30, 2, 0, 0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 10, 2, 0, 0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 10, 0, 0, 0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 10, 0, 0, 0, 1'b0};

        for (int i = 0; i < 13; i++) begin
            btn_raw   = tbl[i].btn;
            sw_raw    = tbl[i].sw;
            repeat_en = tbl[i].rep;
            clr_tally();
            repeat (tbl[i].n) step();
            check($sformatf("vec%0d_pulses", i), cnt_pulse, tbl[i].exp_pulse);
            check($sformatf("vec%0d_rise", i),   cnt_rise,  tbl[i].exp_rise);
            check($sformatf("vec%0d_fall", i),   cnt_fall,  tbl[i].exp_fall);
            check($sformatf("vec%0d_level", i),  int'(sw_level), int'(tbl[i].exp_level));
        end

        // Clean press, no repeat: single pulse on the 7th edge.
        do_reset();
        btn_raw = 1'b1;
        first = -1;
        np = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (btn_pulse) begin
                np++;
                if (first < 0) first = k;
            end
        end
        check("clean_press_latency", first, DB + 3);
        check("clean_press_count", np, 1);

        // Bouncing input: toggles every 2 cycles, last edge is a rise at i=28.
        do_reset();
        first = -1;
        np = 0;
        for (int i = 0; i < 60; i++) begin
            btn_raw = (i >= 28) ? 1'b1 : (((i / 2) % 2) == 0);
            step();
            if (btn_pulse) begin
                np++;
                if (first < 0) first = i;
            end
        end
        check("bounce_pulse_at", first, 34);
        check("bounce_pulse_count", np, 1);

        // Auto-repeat; raw release timed so debounced release coincides with rel 50 terminal count.
        exp_rel = '{0, 20, 25, 30, 35, 40, 45};
        do_reset();
        repeat_en = 1'b1;
        btn_raw   = 1'b1;
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (btn_pulse && first < 0) first = k;
            if (first >= 0) break;
        end
        check("repeat_first_latency", first, DB + 3);
        rel_q.delete();
        rel_q.push_back(0);
        for (int r = 1; r <= 70; r++) begin
            if (r == 44) btn_raw = 1'b0;
            step();
            if (btn_pulse) rel_q.push_back(r);
        end
        check("repeat_pulse_count", rel_q.size(), 7);
        for (int j = 0; j < 7; j++) begin
            check($sformatf("repeat_pulse%0d_at", j), (j < rel_q.size()) ? rel_q[j] : -1, exp_rel[j]);
        end

        // Switch rise then fall: strobe and level change on the same edge.
        do_reset();
        sw_raw = 1'b1;
        rise_at = -1;
        lvl_at  = -1;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (sw_rise && rise_at < 0) rise_at = k;
            if (sw_level && lvl_at < 0) lvl_at = k;
        end
        check("sw_rise_at", rise_at, DB + 3);
        check("sw_level_high_at", lvl_at, DB + 3);
        sw_raw = 1'b0;
        rise_at = -1;
        lvl_at  = -1;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (sw_fall && rise_at < 0) rise_at = k;
            if (!sw_level && lvl_at < 0) lvl_at = k;
        end
        check("sw_fall_at", rise_at, DB + 3);
        check("sw_level_low_at", lvl_at, DB + 3);
        check("sw_rise_total", cnt_rise, 1);
        check("sw_fall_total", cnt_fall, 1);

        // Reset during REPEAT with inputs held high.
        do_reset();
        repeat_en = 1'b1;
        btn_raw   = 1'b1;
        sw_raw    = 1'b1;
        repeat (32) step();
        check("pre_reset_pulse", int'(btn_pulse), 1);
        check("pre_reset_level", int'(sw_level), 1);
        rst = 1'b1;
        #1;
        check("async_reset_pulse", int'(btn_pulse), 0);
        check("async_reset_level", int'(sw_level), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        prev_pulse = 1'b0;
        clr_tally();
        p1 = -1;
        p2 = -1;
        rise_at = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (btn_pulse) begin
                if (p1 < 0) p1 = k;
                else if (p2 < 0) p2 = k;
            end
            if (sw_rise && rise_at < 0) rise_at = k;
        end
        check("post_reset_pulse1", p1, DB + 3);
        check("post_reset_pulse2", p2, DB + 3 + RD);
        check("post_reset_sw_rise_at", rise_at, DB + 3);
        check("post_reset_sw_rise_count", cnt_rise, 1);

        // Reset mid-debounce discards the partial count.
        do_reset();
        sw_raw = 1'b1;
        repeat (4) step();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        clr_tally();
        rise_at = -1;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (sw_rise && rise_at < 0) rise_at = k;
        end
        check("mid_debounce_reset_rise_at", rise_at, DB + 3);
        check("mid_debounce_reset_rise_count", cnt_rise, 1);

        check("no_back_to_back_pulses", dbl_pulse, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 60000; cycles a synchronized input must stay stable before the debounced state changes.
REQ-002 Parameter REPEAT_DELAY, default 6000000; cycles of continuous hold before the first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, default 1200000; cycles between subsequent auto-repeat pulses.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 btn_raw  input  1  raw, asynchronous, bouncing push-button (high = pressed).
REQ-007 sw_raw  input  1  raw, asynchronous, bouncing slide switch (high = count-down enabled).
REQ-008 repeat_en  input  1  enables auto-repeat of btn_pulse while the button is held.
REQ-009 btn_pulse  output  1  one-cycle increment strobe to the timer stage.
REQ-010 sw_level  output  1  debounced switch level.
REQ-011 sw_rise  output  1  one-cycle strobe on a debounced switch 0->1 transition.
REQ-012 sw_fall  output  1  one-cycle strobe on a debounced switch 1->0 transition.

Function
REQ-013 Each raw input SHALL pass through a two-flop synchronizer before any other logic.
REQ-014 Debounce per input: if sync == deb, cnt <= 0; else if cnt == DEBOUNCE_CYCLES-1, deb <= sync and cnt <= 0; else cnt <= cnt+1.
REQ-015 Any bounce (sync returning to deb) before terminal count SHALL clear cnt with no change to deb.
REQ-016 Counters SHALL be wide enough for the largest parameter (23 bits at defaults) and SHALL never wrap.
REQ-017 Button FSM states: IDLE, HELD, REPEAT.
REQ-018 IDLE: debounced button rising edge -> btn_pulse high for exactly one cycle, hold_cnt <= 0, go to HELD.
REQ-019 HELD: hold_cnt increments; at hold_cnt == REPEAT_DELAY-1 with repeat_en high -> one btn_pulse, hold_cnt <= 0, go to REPEAT; with repeat_en low -> stay in HELD, hold_cnt saturates.
REQ-020 REPEAT: at hold_cnt == REPEAT_PERIOD-1 -> one btn_pulse and hold_cnt <= 0; repeat_en going low -> go to HELD with hold_cnt saturated, so no further pulses.
REQ-021 A debounced button release SHALL return the FSM to IDLE from any state, with no pulse in that cycle.
REQ-022 Release and a terminal-count match in the same cycle: release wins, no pulse.
REQ-023 All outputs SHALL be registered; btn_pulse, sw_rise and sw_fall SHALL each assert one cycle after the corresponding deb transition.
REQ-024 End-to-end latency from a clean raw edge to the strobe: DEBOUNCE_CYCLES+3 clock edges.
REQ-025 sw_level SHALL equal the debounced switch state delayed by one cycle, aligned with sw_rise and sw_fall.
REQ-026 btn_pulse SHALL never be high in two consecutive cycles, including when REPEAT_PERIOD == 1.

Reset
REQ-027 rst high SHALL immediately clear all of the following: synchronizers, deb states, counters, FSM (to IDLE), and every output (to 0).
REQ-028 An input held high through reset deassertion SHALL be debounced again from 0 and produce exactly one rising strobe.
REQ-029 Reset asserted mid-debounce or mid-repeat SHALL discard the partial count; no strobe is emitted for it.

Structure
REQ-030 Shared package input_cond_pkg SHALL hold the default parameter constants, the counter width constant, and the button FSM state enumeration.
REQ-031 A one-bit sub-module debounce SHALL contain the synchronizer and debounce counter; it is instantiated once for the button and once for the switch.
REQ-032 Edge detection, the FSM and output registers SHALL reside in input_conditioner.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-033 Clean btn_raw rise held 10 cycles with repeat_en=0 -> a single btn_pulse, 7 edges after the first sampling edge; no more pulses.
REQ-034 btn_raw toggling every 2 cycles for 30 cycles, then high -> no pulse during toggling; exactly one pulse 7 edges after the last toggle.
REQ-035 btn_raw held 50 cycles with repeat_en=1 -> pulses at hold cycles 0, 20, 25, 30, 35, 40, 45 (relative to the first pulse); release -> no further pulses.
REQ-036 sw_raw 0->1 held, later 1->0 held -> exactly one sw_rise and one sw_fall, with sw_level matching between them.
REQ-037 rst pulsed while in REPEAT with btn_raw held high -> outputs 0 at once; after release, one btn_pulse at DEBOUNCE_CYCLES+3, then repeat restarts from HELD.
